// File: rtl/iob_uart16550_stream_pkg.sv
// Shared constants and FSM state type for the stream-to-16550 IOb bridge.

package iob_uart16550_stream_pkg;

  localparam int unsigned RBR_THR = 0;
  localparam int unsigned IER_DLM = 1;
  localparam int unsigned FCR     = 2;
  localparam int unsigned LCR     = 3;
  localparam int unsigned LSR     = 5;

  localparam logic [7:0] FCR_INIT = 8'h07;
  localparam logic [7:0] LCR_DLAB = 8'h80;

  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_OE   = 1;
  localparam int unsigned LSR_BI   = 4;
  localparam int unsigned LSR_THRE = 5;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StPoll,
    StRdRbr,
    StWrThr
  } state_e;

endpackage

// File: rtl/iob_uart16550_stream_acc.sv
// Single IOb access engine: byte-lane steering, rvalid completion and an access watchdog.

module iob_uart16550_stream_acc #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  req_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [7:0]            wbyte_i,
  input  logic                  we_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            rbyte_o,
  output logic                  timeout_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_rvalid_i,
  input  logic                  iob_ready_i
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic                 avalid_q, avalid_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0]     wstrb_q, wstrb_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 unused_ready;

  assign unused_ready = iob_ready_i;

  assign done_o    = avalid_q & iob_rvalid_i;
  // The counter holds the number of request cycles so far, so all-ones marks the last one.
  assign timeout_o = avalid_q & ~iob_rvalid_i & (cnt_q == '1);
  assign rbyte_o   = 8'(iob_rdata_i >> {addr_q[1:0], 3'b000});
  assign busy_o    = avalid_q;

  always_comb begin
    avalid_d = avalid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    cnt_d    = cnt_q;
    if (!avalid_q) begin
      if (req_i) begin
        avalid_d = 1'b1;
        addr_d   = addr_i;
        wdata_d  = DATA_W'(wbyte_i) << {addr_i[1:0], 3'b000};
        wstrb_d  = we_i ? (StrbW'(1) << addr_i[1:0]) : '0;
        cnt_d    = TIMEOUT_W'(1);
      end
    end else if (done_o || timeout_o) begin
      avalid_d = 1'b0;
    end else begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt_q    <= '0;
    end else begin
      avalid_q <= avalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign iob_avalid_o = avalid_q;
  assign iob_addr_o   = addr_q;
  assign iob_wdata_o  = wdata_q;
  assign iob_wstrb_o  = wstrb_q;

endmodule

// File: rtl/iob_uart16550_stream.sv
// IOb master that initialises a 16550 and moves bytes between streams and its THR/RBR.

module iob_uart16550_stream #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 3,
  parameter logic [7:0]  LCR_VAL    = 8'h03,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT_W  = 10
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                start_i,
  input  logic [15:0]         div_i,
  output logic                init_done_o,
  input  logic [7:0]          tx_tdata_i,
  input  logic                tx_tvalid_i,
  output logic                tx_tready_o,
  output logic [7:0]          rx_tdata_o,
  output logic                rx_tvalid_o,
  input  logic                rx_tready_i,
  output logic [3:0]          line_err_o,
  output logic                bus_err_o,
  input  logic                err_clr_i,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_rvalid_i,
  input  logic                iob_ready_i
);

  import iob_uart16550_stream_pkg::*;

  localparam int unsigned BurstW = $clog2(FIFO_DEPTH + 1);

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [15:0]         div_q, div_d;
  logic                pend_q, pend_d;
  logic                prio_q, prio_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic                init_done_q, init_done_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [3:0]          line_err_q, line_err_d;
  logic                bus_err_q, bus_err_d;

  logic                acc_req, acc_we, acc_busy, acc_done, acc_timeout;
  logic [ADDR_W-1:0]   acc_addr;
  logic [7:0]          acc_wbyte, acc_rbyte;
  logic                rd_ok, wr_ok;

  iob_uart16550_stream_acc #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .TIMEOUT_W(TIMEOUT_W)
  ) u_acc (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .req_i       (acc_req),
    .addr_i      (acc_addr),
    .wbyte_i     (acc_wbyte),
    .we_i        (acc_we),
    .busy_o      (acc_busy),
    .done_o      (acc_done),
    .rbyte_o     (acc_rbyte),
    .timeout_o   (acc_timeout),
    .iob_avalid_o(iob_avalid_o),
    .iob_addr_o  (iob_addr_o),
    .iob_wdata_o (iob_wdata_o),
    .iob_wstrb_o (iob_wstrb_o),
    .iob_rdata_i (iob_rdata_i),
    .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i (iob_ready_i)
  );

  assign rd_ok       = acc_rbyte[LSR_DR] & ~rx_valid_q;
  assign wr_ok       = acc_rbyte[LSR_THRE] & tx_tvalid_i;
  assign tx_tready_o = (state_q == StWrThr) & acc_done;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    div_d       = div_q;
    pend_d      = pend_q;
    prio_d      = prio_q;
    burst_d     = burst_q;
    init_done_d = init_done_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    // A new error in the clearing cycle survives the clear.
    line_err_d  = err_clr_i ? 4'b0000 : line_err_q;
    bus_err_d   = (err_clr_i ? 1'b0 : bus_err_q) | acc_timeout;
    acc_req     = 1'b0;
    acc_addr    = '0;
    acc_wbyte   = 8'h00;
    acc_we      = 1'b0;

    if (rx_valid_q && rx_tready_i) rx_valid_d = 1'b0;
    if (start_i) begin
      div_d = div_i;
      if (state_q != StIdle) pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StInit;
          step_d      = 3'd0;
          init_done_d = 1'b0;
        end
      end
      StInit: begin
        acc_req = 1'b1;
        acc_we  = 1'b1;
        unique case (step_q)
          3'd0: begin acc_addr = ADDR_W'(LCR);     acc_wbyte = LCR_VAL | LCR_DLAB; end
          3'd1: begin acc_addr = ADDR_W'(RBR_THR); acc_wbyte = div_q[7:0];         end
          3'd2: begin acc_addr = ADDR_W'(IER_DLM); acc_wbyte = div_q[15:8];        end
          3'd3: begin acc_addr = ADDR_W'(LCR);     acc_wbyte = LCR_VAL;            end
          3'd4: begin acc_addr = ADDR_W'(FCR);     acc_wbyte = FCR_INIT;           end
          default: begin acc_addr = ADDR_W'(IER_DLM); acc_wbyte = 8'h00;           end
        endcase
        if (acc_done) begin
          if (step_q == 3'd5) begin
            init_done_d = 1'b1;
            state_d     = StPoll;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      StPoll: begin
        if (!acc_busy && pend_q) begin
          state_d     = StInit;
          step_d      = 3'd0;
          pend_d      = start_i;
          init_done_d = 1'b0;
        end else begin
          acc_req  = ~pend_q;
          acc_addr = ADDR_W'(LSR);
          if (acc_done) begin
            line_err_d = line_err_d | acc_rbyte[LSR_BI:LSR_OE];
            if (rd_ok && (!wr_ok || !prio_q)) begin
              state_d = StRdRbr;
            end else if (wr_ok) begin
              state_d = StWrThr;
              burst_d = BurstW'(FIFO_DEPTH);
            end
            if (rd_ok && wr_ok) prio_d = ~prio_q;
          end
        end
      end
      StRdRbr: begin
        acc_req  = 1'b1;
        acc_addr = ADDR_W'(RBR_THR);
        if (acc_done) begin
          rx_data_d  = acc_rbyte;
          rx_valid_d = 1'b1;
          state_d    = StPoll;
        end
      end
      StWrThr: begin
        if (!acc_busy && (burst_q == '0 || !tx_tvalid_i)) begin
          state_d = StPoll;
        end else begin
          acc_req   = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = ADDR_W'(RBR_THR);
          acc_wbyte = tx_tdata_i;
          if (acc_done) burst_d = burst_q - BurstW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (acc_timeout) begin
      state_d     = StIdle;
      init_done_d = 1'b0;
      pend_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StIdle;
      step_q      <= 3'd0;
      div_q       <= 16'h0000;
      pend_q      <= 1'b0;
      prio_q      <= 1'b0;
      burst_q     <= '0;
      init_done_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      line_err_q  <= 4'b0000;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      prio_q      <= prio_d;
      burst_q     <= burst_d;
      init_done_q <= init_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      line_err_q  <= line_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign init_done_o = init_done_q;
  assign rx_tdata_o  = rx_data_q;
  assign rx_tvalid_o = rx_valid_q;
  assign line_err_o  = line_err_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_iob_uart16550_stream.sv
// Directed bench: a small 16550 register model answers the IOb accesses and logs them.

module tb_iob_uart16550_stream;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [15:0] div;
  logic        init_done;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [3:0]  line_err;
  logic        bus_err;
  logic        err_clr;
  logic        iob_avalid;
  logic [2:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [31:0] iob_rdata = 32'h0;
  logic        iob_rvalid = 1'b0;

  always #5 clk = ~clk;

  iob_uart16550_stream dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .start_i     (start),
    .div_i       (div),
    .init_done_o (init_done),
    .tx_tdata_i  (tx_tdata),
    .tx_tvalid_i (tx_tvalid),
    .tx_tready_o (tx_tready),
    .rx_tdata_o  (rx_tdata),
    .rx_tvalid_o (rx_tvalid),
    .rx_tready_i (rx_tready),
    .line_err_o  (line_err),
    .bus_err_o   (bus_err),
    .err_clr_i   (err_clr),
    .iob_avalid_o(iob_avalid),
    .iob_addr_o  (iob_addr),
    .iob_wdata_o (iob_wdata),
    .iob_wstrb_o (iob_wstrb),
    .iob_rdata_i (iob_rdata),
    .iob_rvalid_i(iob_rvalid),
    .iob_ready_i (1'b1)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic       we;
    logic       ok;
  } acc_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } init_vec_t;

  typedef struct {
    logic [7:0] lsr;
    logic       clr;
    logic       clr_on_poll;
    logic [3:0] exp;
  } err_vec_t;

  acc_t       log_q[$];
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_val = 8'h00;
  logic       withhold = 1'b0;
  logic       late_pulse = 1'b0;
  logic       after_rv = 1'b0;
  int         gap_err = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         tx_idx;
  int         w0, nm, nt, alt, cnt;
  logic       types[4];
  init_vec_t  init_tbl[6];
  err_vec_t   err_tbl[6];

  function automatic logic [7:0] model_byte(logic [2:0] a);
    if (a == 3'd5) return lsr_val;
    if (a == 3'd0) return rbr_val;
    return 8'h00;
  endfunction

  function automatic acc_t mk_entry();
    acc_t e;
    logic [31:0] mask;
    mask   = 32'hFF << {iob_addr[1:0], 3'b000};
    e.addr = iob_addr;
    e.we   = |iob_wstrb;
    e.data = e.we ? 8'(iob_wdata >> {iob_addr[1:0], 3'b000})
                  : 8'(iob_rdata >> {iob_addr[1:0], 3'b000});
    e.ok   = e.we ? ((iob_wstrb == (4'b0001 << iob_addr[1:0])) && ((iob_wdata & ~mask) == 0))
                  : 1'b1;
    return e;
  endfunction

  // Model: rvalid one cycle after avalid is seen, unless withheld.
  always @(posedge clk) begin
    iob_rvalid <= (iob_avalid && !iob_rvalid && !withhold) || late_pulse;
    iob_rdata  <= 32'(model_byte(iob_addr)) << {iob_addr[1:0], 3'b000};
    if (iob_avalid && iob_rvalid) log_q.push_back(mk_entry());
    if (after_rv && iob_avalid) gap_err <= gap_err + 1;
    after_rv <= iob_avalid && iob_rvalid;
  end

  function automatic logic [31:0] pk(logic ok, logic we, logic [2:0] a, logic [7:0] d);
    return {19'd0, ok, we, a, d};
  endfunction

  function automatic logic [31:0] get(int i);
    if (i < 0 || i >= log_q.size()) return 32'hFFFF_FFFF;
    return pk(log_q[i].ok, log_q[i].we, log_q[i].addr, log_q[i].data);
  endfunction

  function automatic int count_rbr_reads();
    int n = 0;
    foreach (log_q[i]) if (!log_q[i].we && log_q[i].addr == 3'd0) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input logic lvl, input int max, input string name);
    for (int i = 0; i < max && init_done !== lvl; i++) @(negedge clk);
    check(name, 32'(init_done), 32'(lvl));
  endtask

  task automatic wait_avalid(input logic lvl, input int max, input string name);
    for (int i = 0; i < max && iob_avalid !== lvl; i++) @(negedge clk);
    check(name, 32'(iob_avalid), 32'(lvl));
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic run_tx(input int nbytes, input int max);
    tx_idx    = 0;
    tx_tdata  = 8'h00;
    tx_tvalid = 1'b1;
    for (int c = 0; c < max && tx_idx < nbytes; c++) begin
      @(negedge clk);
      if (tx_tready) begin
        tx_idx++;
        tx_tdata  = 8'(tx_idx);
        tx_tvalid = (tx_idx < nbytes);
      end
    end
    tx_tvalid = 1'b0;
  endtask

  initial begin
    init_tbl = '{'{3'd3, 8'h83}, '{3'd0, 8'h1B}, '{3'd1, 8'h00},
                 '{3'd3, 8'h03}, '{3'd2, 8'h07}, '{3'd1, 8'h00}};
    err_tbl  = '{'{8'h0B, 1'b0, 1'b0, 4'b0101},
                 '{8'h00, 1'b1, 1'b0, 4'b0000},
                 '{8'h11, 1'b0, 1'b0, 4'b1000},
                 '{8'h04, 1'b0, 1'b0, 4'b1010},
                 '{8'h0B, 1'b0, 1'b1, 4'b0101},
                 '{8'h00, 1'b1, 1'b0, 4'b0000}};
    arst = 1'b1; start = 1'b0; div = 16'h0; tx_tdata = 8'h0; tx_tvalid = 1'b0;
    rx_tready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_init_done", 32'(init_done), 0);
    check("rst_avalid", 32'(iob_avalid), 0);
    check("rst_wstrb", 32'(iob_wstrb), 0);
    check("rst_wdata", iob_wdata, 0);
    check("rst_rx_tvalid", 32'(rx_tvalid), 0);
    check("rst_errs", 32'({line_err, bus_err, tx_tready}), 0);
    arst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_access", 32'(iob_avalid), 0);

    // Init sequence
    log_q.delete();
    start = 1'b1; div = 16'h001B;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, 200, "init_done");
    for (int i = 0; i < 6; i++)
      check($sformatf("init_wr%0d", i), get(i), pk(1'b1, 1'b1, init_tbl[i].addr, init_tbl[i].data));

    // TX burst: 16 writes, one poll, 4 writes
    lsr_val = 8'h60;
    log_q.delete();
    run_tx(20, 3000);
    check("tx_tready_pulses", 32'(tx_idx), 20);
    repeat (10) @(negedge clk);
    lsr_val = 8'h00;
    w0 = log_q.size();
    for (int i = log_q.size() - 1; i >= 0; i--) if (log_q[i].we && log_q[i].addr == 3'd0) w0 = i;
    nm = 0;
    for (int k = 0; k < 16; k++) if (get(w0 + k) == pk(1'b1, 1'b1, 3'd0, 8'(k))) nm++;
    check("tx_burst1", 32'(nm), 16);
    check("tx_poll_between", get(w0 + 16) & 32'h0F00, 32'h0500);
    nm = 0;
    for (int k = 0; k < 4; k++) if (get(w0 + 17 + k) == pk(1'b1, 1'b1, 3'd0, 8'(16 + k))) nm++;
    check("tx_burst2", 32'(nm), 4);

    // RX hold and single read until handshake
    repeat (10) @(negedge clk);
    log_q.delete();
    rbr_val = 8'h5A; lsr_val = 8'h61; rx_tready = 1'b0;
    repeat (100) @(negedge clk);
    check("rx_valid", 32'(rx_tvalid), 1);
    check("rx_data", 32'(rx_tdata), 32'h5A);
    check("rx_one_read", 32'(count_rbr_reads()), 1);
    rbr_val = 8'hA5;
    rx_tready = 1'b1;
    @(negedge clk);
    rx_tready = 1'b0;
    repeat (50) @(negedge clk);
    check("rx_second_data", 32'(rx_tdata), 32'hA5);
    check("rx_second_read", 32'(count_rbr_reads()), 2);
    lsr_val = 8'h00; rx_tready = 1'b1;
    repeat (10) @(negedge clk);
    check("rx_drained", 32'(rx_tvalid), 0);

    // RD/WR alternation with both possible
    log_q.delete();
    lsr_val = 8'h63; rbr_val = 8'h33;
    run_tx(40, 4000);
    lsr_val = 8'h00;
    repeat (10) @(negedge clk);
    nt = 0;
    types = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i + 1 < log_q.size(); i++)
      if (!log_q[i].we && log_q[i].addr == 3'd5 && log_q[i + 1].addr == 3'd0) begin
        if (nt < 4) types[nt] = log_q[i + 1].we;
        nt++;
      end
    check("alt_count", 32'(nt >= 4), 1);
    alt = 0;
    for (int k = 1; k < 4; k++) if (types[k] != types[k - 1]) alt++;
    check("alt_pattern", 32'(alt), 3);
    check("oe_sticky", 32'(line_err), 32'b0001);
    pulse_clr();
    @(negedge clk);
    check("oe_cleared", 32'(line_err), 0);

    // Line error table
    for (int v = 0; v < 6; v++) begin
      lsr_val = err_tbl[v].lsr;
      if (err_tbl[v].clr_on_poll) begin
        @(negedge clk);
        for (int i = 0; i < 100 && !(iob_rvalid && iob_avalid && iob_addr == 3'd5); i++)
          @(negedge clk);
        lsr_val = 8'h00;
        pulse_clr();
      end else begin
        repeat (12) @(negedge clk);
        lsr_val = 8'h00;
        repeat (8) @(negedge clk);
        if (err_tbl[v].clr) pulse_clr();
      end
      repeat (2) @(negedge clk);
      check($sformatf("line_err_vec%0d", v), 32'(line_err), 32'(err_tbl[v].exp));
    end

    // Watchdog
    wait_avalid(1'b0, 20, "wd_pre_idle");
    withhold = 1'b1;
    cnt = 0;
    for (int c = 0; c < 1500 && !bus_err; c++) begin
      @(negedge clk);
      if (iob_avalid) cnt++;
    end
    check("wd_bus_err", 32'(bus_err), 1);
    check("wd_cycles", 32'(cnt), 1023);
    check("wd_avalid_low", 32'(iob_avalid), 0);
    check("wd_init_cleared", 32'(init_done), 0);
    withhold = 1'b0;
    late_pulse = 1'b1;
    @(negedge clk);
    late_pulse = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (iob_avalid) cnt++;
    end
    check("wd_stays_idle", 32'(cnt), 0);
    check("wd_late_rvalid_ignored", 32'({init_done, rx_tvalid}), 0);
    pulse_clr();
    check("bus_err_cleared", 32'(bus_err), 0);
    log_q.delete();
    start = 1'b1; div = 16'h0102;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, 200, "reinit_done");
    check("reinit_dll", get(1), pk(1'b1, 1'b1, 3'd0, 8'h02));
    check("reinit_dlm", get(2), pk(1'b1, 1'b1, 3'd1, 8'h01));

    // start_i during an access is held pending
    log_q.delete();
    wait_avalid(1'b1, 20, "pend_busy");
    start = 1'b1; div = 16'h0405;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 50, "pend_init_begin");
    wait_done(1'b1, 200, "pend_init_done");
    nm = 0;
    foreach (log_q[i]) if (get(i) == pk(1'b1, 1'b1, 3'd0, 8'h05)) nm++;
    check("pend_dll", 32'(nm), 1);

    // Asynchronous reset mid-access
    wait_avalid(1'b1, 20, "arst_busy");
    arst = 1'b1;
    #1;
    check("arst_avalid", 32'(iob_avalid), 0);
    check("arst_init_done", 32'(init_done), 0);
    @(negedge clk);
    arst = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_idle", 32'(iob_avalid), 0);

    check("access_gap", 32'(gap_err), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_uart16550_stream.md
Name: iob_uart16550_stream

Overview:
- IOb-bus master that sits directly upstream of the UART16550 IOb peripheral and drives its register file.
- Turns a byte-stream TX interface and an RX interface into 16550 register accesses: initialisation, LSR polling, THR writes and RBR reads.
- Lets stream-based cores (DMA, console logic) use the UART without a CPU.

Parameters:
- DATA_W, 32, IOb data width; byte lanes are selected by addr[1:0].
- ADDR_W, 3, IOb address width (16550 register offset).
- LCR_VAL, 8'h03, line-control value written at init (8N1).
- FIFO_DEPTH, 16, maximum THR writes per observed THRE.
- TIMEOUT_W, 10, width of the access watchdog counter.

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- start_i  in  1  pulse: (re)initialise the UART using div_i
- div_i  in  16  baud divisor, sampled when start_i is accepted
- init_done_o  out  1  init sequence complete
- tx_tdata_i  in  8  byte to transmit
- tx_tvalid_i  in  1  TX byte valid
- tx_tready_o  out  1  one-cycle pulse: byte written to THR
- rx_tdata_o  out  8  received byte
- rx_tvalid_o  out  1  RX byte valid, held until taken
- rx_tready_i  in  1  RX consumer ready
- line_err_o  out  4  sticky LSR[4:1] (BI, FE, PE, OE)
- bus_err_o  out  1  sticky access timeout
- err_clr_i  in  1  clears line_err_o and bus_err_o
- iob_avalid_o  out  1  access request
- iob_addr_o  out  ADDR_W  register offset
- iob_wdata_o  out  DATA_W  write data
- iob_wstrb_o  out  DATA_W/8  write strobe; zero means read
- iob_rdata_i  in  DATA_W  read data
- iob_rvalid_i  in  1  access acknowledge (reads and writes)
- iob_ready_i  in  1  unused beyond lint; completion is signalled by rvalid

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters cleared.
- Bus access:
  - avalid rises with addr, wdata and wstrb stable, and is held through the cycle rvalid_i=1.
  - avalid drops the next cycle; at least one idle cycle separates accesses.
  - Byte data goes on lane addr[1:0], other lanes 0; wstrb = 1<<addr[1:0] for writes.
  - Read byte is taken from lane addr[1:0] in the rvalid cycle.
- Watchdog:
  - Counts cycles while avalid=1. At all-ones it sets bus_err_o, drops avalid, clears init_done_o and goes to IDLE.
  - A late rvalid arriving in IDLE is ignored.
- IDLE: waits for start_i.
- Init sequence, one access each, in order:
  - LCR = LCR_VAL|0x80
  - DLL (offset 0) = div[7:0]
  - DLM (offset 1) = div[15:8]
  - LCR = LCR_VAL
  - FCR (offset 2) = 0x07
  - IER (offset 1) = 0x00
  - Then init_done_o=1 and go to POLL.
- POLL: read LSR (offset 5).
  - Any of LSR[4:1] set: OR them into line_err_o.
  - DR=LSR[0]; THRE=LSR[5].
  - Branch to RD_RBR or WR_THR as below, else re-POLL.
- Priority: prio flag. When both RD and WR are possible, serve the one the flag selects, then toggle the flag.
- RD_RBR:
  - Allowed only if rx_tvalid_o=0.
  - Read offset 0, load rx_tdata_o and set rx_tvalid_o in the rvalid cycle; return to POLL.
  - rx_tvalid_o clears on rx_tvalid_o&rx_tready_i.
- WR_THR:
  - Entered on THRE=1 and tx_tvalid_i=1; burst counter loads FIFO_DEPTH.
  - Each write to offset 0 pulses tx_tready_o in its rvalid cycle and decrements the counter.
  - Next write starts immediately while counter≠0 and tx_tvalid_i=1; otherwise return to POLL.
  - tx_tdata_i is sampled at avalid rise and must be held until tx_tready_o.
- start_i:
  - Outside IDLE it is latched pending and honoured at the next POLL entry.
  - It never aborts an access in flight; init_done_o clears when init starts.
- err_clr_i in the same cycle as a new error: the new error wins (set).
- Mid-operation reset: avalid drops asynchronously; all state is lost.

Decomposition:
- Package iob_uart16550_stream_pkg holds:
  - register offsets RBR_THR=0, IER_DLM=1, FCR=2, LCR=3, LSR=5
  - FCR_INIT=8'h07, LCR_DLAB=8'h80
  - LSR bit indices
  - FSM state enum
- Sub-module iob_uart16550_stream_acc performs one IOb access with watchdog.
  - Inputs: req, addr, wbyte, we.
  - Outputs: done, rbyte, timeout.

Test Plan:
- start_i with div_i=16'h001B against the UART model → bus writes observed in order: 3:0x83, 0:0x1B, 1:0x00, 3:0x03, 2:0x07, 1:0x00; then init_done_o=1.
- tx_tvalid_i held with 20 bytes 0x00..0x13, model THRE=1 → 16 THR writes without an intervening LSR read, then an LSR poll, then the remaining 4; 20 tx_tready_o pulses.
- Model RX byte 0x5A, LSR=0x61, rx_tready_i=0 → one RBR read; rx_tdata_o=0x5A held; no further RBR read until the handshake, even with DR=1.
- LSR=0x63 with TX pending → RD and WR alternate on consecutive poll results.
- LSR=0x0B → line_err_o=4'b0101; err_clr_i clears to 0; clear coinciding with a new error leaves it set.
- Model withholds rvalid → after 1023 cycles bus_err_o=1, avalid=0, state IDLE; a subsequent start_i re-runs init.
